// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// Holds the operand width, the iteration count and the FSM state encoding.
package mult_pkg;

  localparam int MULT_WIDTH = 32;
  localparam int MULT_ITERS = 32;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_RUN  = 2'd1,
    MS_DONE = 2'd2
  } mult_state_e;

endpackage

// File: rtl/mult_addsub.sv
// 33-bit add-with-carry slice of the shift-add multiplier.
// Adds the multiplicand to the upper accumulator half when the current
// multiplier bit is set; the carry is kept as the extra top bit.
module mult_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] mcand,
  input  logic             add_en,
  output logic [WIDTH:0]   sum
);

  // Either pass the upper half through or add the multiplicand, keeping carry
  always_comb begin
    sum = {1'b0, hi};
    if (add_en) begin
      sum = {1'b0, hi} + {1'b0, mcand};
    end
  end

endmodule

// File: rtl/seq_mult_32.sv
// Sequential 32x32 shift-add multiplier with fixed 32-iteration latency.
// A start pulse in IDLE or DONE launches an operation; done strobes for one
// cycle when prod is loaded, and prod holds until the next completion.
// Optional feature macro: SIGNED_MUL_EN (signed multiply when sgn=1).
module seq_mult_32
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sgn,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = $clog2(MULT_ITERS);

  mult_state_e          state;
  mult_state_e          state_next;
  logic [WIDTH-1:0]     mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        cnt;
  logic                 accept;
  logic                 last_iter;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   acc_step;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic [2*WIDTH-1:0]   result;

`ifdef SIGNED_MUL_EN
  logic                 neg;
  logic                 neg_next;
`else
  logic                 unused_sgn;
  assign unused_sgn = sgn;
`endif

  assign accept    = start && ((state == MS_IDLE) || (state == MS_DONE));
  assign last_iter = (cnt == CW'(MULT_ITERS - 1));
  assign busy      = (state == MS_RUN);
  assign done      = (state == MS_DONE);

  mult_addsub #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .hi     (acc[2*WIDTH-1:WIDTH]),
    .mcand  (mcand),
    .add_en (acc[0]),
    .sum    (sum)
  );

  // One iteration: add-with-carry into the upper half, then shift right by one
  assign acc_step = {sum, acc[WIDTH-1:1]};

  // Operand conditioning: magnitudes and result sign for signed requests
  always_comb begin
    op_a = a;
    op_b = b;
`ifdef SIGNED_MUL_EN
    neg_next = 1'b0;
    if (sgn) begin
      if (a[WIDTH-1]) op_a = -a;
      if (b[WIDTH-1]) op_b = -b;
      neg_next = a[WIDTH-1] ^ b[WIDTH-1];
    end
`endif
  end

  // Final product after the last iteration, negated when the signs differed
  always_comb begin
    result = acc_step;
`ifdef SIGNED_MUL_EN
    if (neg) result = -acc_step;
`endif
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MS_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic; DONE accepts a new start for back-to-back operation
  always_comb begin
    state_next = state;
    case (state)
      MS_IDLE: if (start) state_next = MS_RUN;
      MS_RUN:  if (last_iter) state_next = MS_DONE;
      MS_DONE: state_next = start ? MS_RUN : MS_IDLE;
      default: state_next = MS_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, counter and product register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
      prod  <= '0;
`ifdef SIGNED_MUL_EN
      neg   <= 1'b0;
`endif
    end else if (accept) begin
      mcand <= op_a;
      acc   <= {{WIDTH{1'b0}}, op_b};
      cnt   <= '0;
`ifdef SIGNED_MUL_EN
      neg   <= neg_next;
`endif
    end else if (state == MS_RUN) begin
      acc <= acc_step;
      cnt <= cnt + 1'b1;
      if (last_iter) begin
        prod <= result;
      end
    end
  end

endmodule

// File: tb/tb_seq_mult_32.sv
// Directed self-checking bench for seq_mult_32.
// Covers reset, unsigned vectors, handshake, back-to-back and the
// SIGNED_MUL_EN dependent behaviour.
module tb_seq_mult_32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        sgn;
  logic        busy;
  logic        done;
  logic [63:0] prod;

  int checks = 0;
  int errors = 0;

  seq_mult_32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .sgn   (sgn),
    .busy  (busy),
    .done  (done),
    .prod  (prod)
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic st, input logic [31:0] ta,
                               input logic [31:0] tb, input logic ts);
    start = st;
    a     = ta;
    b     = tb;
    sgn   = ts;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Launch one operation and wait (bounded) for done; inputs change #1 after edges
  task automatic runOp(input logic [31:0] ta, input logic [31:0] tb,
                       input logic ts, output logic [63:0] p,
                       output int lat, output logic busyAfter);
    applyStimulus(1'b1, ta, tb, ts);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
    busyAfter = busy;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
    end
    p = prod;
  endtask

  initial begin
    logic [63:0] p;
    int          lat;
    logic        busyAfter;
    int          doneCount;
    int          overlap;
    int          notHeld;

    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", {63'h0, busy}, 64'h0);
    checkOutput("reset_done", {63'h0, done}, 64'h0);
    checkOutput("reset_prod", prod, 64'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset in the middle of an operation
    applyStimulus(1'b1, 32'd7, 32'd9, 1'b0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("midrun_busy", {63'h0, busy}, 64'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", {63'h0, busy}, 64'h0);
    checkOutput("midrst_done", {63'h0, done}, 64'h0);
    checkOutput("midrst_prod", prod, 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    runOp(32'd3, 32'd5, 1'b0, p, lat, busyAfter);
    checkOutput("post_rst_busy", {63'h0, busyAfter}, 64'h1);
    checkOutput("post_rst_prod", p, 64'd15);
    checkOutput("post_rst_lat", 64'(lat), 64'd32);

    // Unsigned vectors
    runOp(32'h12345678, 32'h9ABCDEF0, 1'b0, p, lat, busyAfter);
    checkOutput("u_basic", p, 64'h0B00EA4E242D2080);
    checkOutput("u_basic_busy_at_done", {63'h0, busy}, 64'h0);
    runOp(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, p, lat, busyAfter);
    checkOutput("u_max", p, 64'hFFFFFFFE00000001);
    checkOutput("u_max_lat", 64'(lat), 64'd32);
    runOp(32'h0, 32'hFFFFFFFF, 1'b0, p, lat, busyAfter);
    checkOutput("u_zero", p, 64'h0);
    checkOutput("u_zero_lat", 64'(lat), 64'd32);
    @(posedge clk);
    #1;
    checkOutput("done_one_cycle", {63'h0, done}, 64'h0);

    // Start held during RUN with different operands must be ignored
    applyStimulus(1'b1, 32'd6, 32'd7, 1'b0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
    doneCount = 0;
    overlap   = 0;
    for (int i = 1; i <= 36; i++) begin
      if (i >= 3 && i <= 12) applyStimulus(1'b1, 32'd100, 32'd100, 1'b0);
      else applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
      @(posedge clk);
      #1;
      if (done) doneCount++;
      if (done && busy) overlap++;
      if (i == 32) checkOutput("hs_prod", prod, 64'd42);
      if (i == 32) checkOutput("hs_done_at_32", {63'h0, done}, 64'h1);
    end
    checkOutput("hs_done_count", 64'(doneCount), 64'd1);
    checkOutput("hs_overlap", 64'(overlap), 64'd0);

    // Back-to-back: relaunch on the DONE cycle
    runOp(32'd4, 32'd5, 1'b0, p, lat, busyAfter);
    checkOutput("b2b_first", p, 64'd20);
    applyStimulus(1'b1, 32'd2, 32'd3, 1'b0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
    checkOutput("b2b_busy", {63'h0, busy}, 64'h1);
    checkOutput("b2b_done_low", {63'h0, done}, 64'h0);
    lat = 1;
    notHeld = 0;
    while (!done && lat < 40) begin
      if (prod !== 64'd20) notHeld++;
      @(posedge clk);
      lat++;
      #1;
    end
    checkOutput("b2b_hold", 64'(notHeld), 64'd0);
    checkOutput("b2b_second", prod, 64'd6);
    checkOutput("b2b_spacing", 64'(lat), 64'd33);

`ifdef SIGNED_MUL_EN
    runOp(32'hFFFFFFFD, 32'd5, 1'b1, p, lat, busyAfter);
    checkOutput("s_neg3x5", p, 64'hFFFFFFFFFFFFFFF1);
    runOp(32'h80000000, 32'h80000000, 1'b1, p, lat, busyAfter);
    checkOutput("s_minxmin", p, 64'h4000000000000000);
    runOp(32'h80000000, 32'd1, 1'b1, p, lat, busyAfter);
    checkOutput("s_minx1", p, 64'hFFFFFFFF80000000);
    checkOutput("s_minx1_lat", 64'(lat), 64'd32);
    runOp(32'hFFFFFFFF, 32'd2, 1'b0, p, lat, busyAfter);
    checkOutput("s_sgn0", p, 64'h00000001FFFFFFFE);
`else
    runOp(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, p, lat, busyAfter);
    checkOutput("nosigned_sgn1", p, 64'hFFFFFFFE00000001);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
